// File: rtl/add_serial_pkg.sv
// Shared types and constants for the bit-serial adder
// feeder and the adder it drives.
package add_serial_pkg;

  localparam int ADD_WIDTH = 8;
  localparam int ADD_LAT   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/add_serial_feed_if.sv
// Operand stream, adder hookup and result stream
// of the serial-adder feeder.
interface add_serial_feed_if
  import add_serial_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             add_en;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  modport master (
    input  in_valid, in_a, in_b,
    input  add_out, res_ready,
    output in_ready, add_en,
    output add_a, add_b,
    output res_valid, res_sum, res_cout
  );

  modport slave (
    output in_valid, in_a, in_b,
    output add_out, res_ready,
    input  in_ready, add_en,
    input  add_a, add_b,
    input  res_valid, res_sum, res_cout
  );

endinterface

// File: rtl/add_serial_fifo.sv
// Small synchronous FIFO with a first-word-fall-through
// head; callers never push when full or pop when empty.
module add_serial_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/add_serial_feed.sv
// Feeds operand pairs to the bit-serial adder, waits out
// its latency and presents sum plus carry-out downstream.
module add_serial_feed
  import add_serial_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int LAT   = ADD_LAT,
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  add_serial_feed_if.master bus
);

  localparam int CW = $clog2(LAT);
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  state_t             state;
  state_t             state_n;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   op_a;
  logic [2*WIDTH-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               capture;
  logic               slot_free;
  logic               add_en;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               res_valid;
  logic [WIDTH-1:0]   res_sum;
  logic               res_cout;

  assign bus.in_ready  = !rst && !full;
  assign bus.add_en    = add_en;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.res_valid = res_valid;
  assign bus.res_sum   = res_sum;
  assign bus.res_cout  = res_cout;

  assign push      = bus.in_valid && bus.in_ready;
  assign slot_free = !res_valid || bus.res_ready;

  add_serial_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .din   ({bus.in_a, bus.in_b}),
    .dout  (head)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          capture = slot_free;
          state_n = slot_free ? IDLE : HOLD;
        end
      end
      HOLD: begin
        // adder output stays put while en is low
        if (slot_free) begin
          capture = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      add_en    <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
    end else begin
      state  <= state_n;
      add_en <= pop;
      if (pop) begin
        {add_a, add_b} <= head;
        op_a           <= head[2*WIDTH-1:WIDTH];
        cnt            <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        res_sum   <= bus.add_out;
        res_cout  <= (bus.add_out < op_a);
        res_valid <= 1'b1;
      end else if (bus.res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
